// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder: two half adders plus an OR for the carry.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic hs1;
   logic hc1;
   logic hc2;

   assign hs1 = a ^ b;
   assign hc1 = a & b;
   assign s   = hs1 ^ cin;
   assign hc2 = hs1 & cin;
   assign co  = hc1 | hc2;

   specify
      (a, b, cin *> s)  = 1;
      (a, b, cin *> co) = 2;
   endspecify

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional subtract mode (extra sub port) when SERIAL_ADD_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high once out of reset
// SHIFT | one sum bit per cycle until the counter reaches WIDTH
// DONE  | sum/cout held, out_valid high until out_ready
module bit_serial_adder
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q;
   logic             sub_q;
   logic             sub_d;
   logic             fa_s;
   logic             fa_co;
   logic             cnt_tc;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_d = sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
      end else if (state_q == IDLE && in_valid && in_ready_q) begin
         sub_q <= sub;
      end
   end
`else
   assign sub_d = 1'b0;
   assign sub_q = 1'b0;
`endif

   // Subtraction is a + ~b + 1: invert b into the cell, carry preset on accept.
   fa_cell u_fa (
      .a   (a_q[0]),
      .b   (b_q[0] ^ sub_q),
      .cin (carry_q),
      .s   (fa_s),
      .co  (fa_co)
   );

   assign cnt_tc = (cnt_q == CW'(WIDTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  sum_q      <= '0;
                  carry_q    <= sub_d;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_tc) begin
                  state_q <= DONE;
               end else begin
                  sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                  carry_q <= fa_co;
                  a_q     <= a_q >> 1;
                  b_q     <= b_q >> 1;
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = carry_q;

endmodule
